cv32e41p_trace_buffer: RTL and testbench
========================================

# cv32e41p_trace_buffer

Multi-hart retired-instruction trace capture buffer for simulation and debug builds. It samples per-hart decode/retire events (PC, instruction word, illegal flag) from `NUM_HARTS` cores and arbitrates them round-robin into one shared FIFO of `DEPTH` entries. The FIFO drains through a valid/ready stream to a trace sink or off-chip trace port. Sources are never stalled; events that cannot be held are dropped and counted.

## Interface
Parameters:
- `NUM_HARTS`, 2: number of event sources; 1..8.
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `TS_W`, 32: timestamp width; used only with `CV32E41P_TRACE_TIMESTAMP_EN`.
- `HART_W`, `$clog2(NUM_HARTS)` (minimum 1): hart index width (derived).

Ports:
- One clock; reset is synchronous and active-high.
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous active-high reset.
- `enable_i` in 1: capture enable.
- `ev_valid_i` in NUM_HARTS: per-hart event strobe.
- `ev_pc_i` in NUM_HARTS×32: per-hart PC.
- `ev_instr_i` in NUM_HARTS×32: per-hart instruction word.
- `ev_illegal_i` in NUM_HARTS: per-hart illegal-instruction flag.
- `tr_valid_o` out 1: FIFO head valid.
- `tr_ready_i` in 1: sink accepts head.
- `tr_hart_o` out HART_W: head hart index.
- `tr_pc_o` out 32: head PC.
- `tr_instr_o` out 32: head instruction.
- `tr_illegal_o` out 1: head illegal flag.
- `tr_ts_o` out TS_W: head timestamp (present only with macro).
- `level_o` out `$clog2(DEPTH)+1`: FIFO occupancy.
- `drop_cnt_o` out 16: saturating dropped-event count.
- `drop_clr_i` in 1: clear drop counter.

## Operation
- Stage 1: one pending register per hart (`pend_v`, payload). Event accepted into hart h when `enable_i & ev_valid_i[h]` and (`!pend_v[h]`, or hart h is granted this cycle). Otherwise the event is dropped.
- `enable_i` low: new events are ignored. They are not counted as drops. Pending entries and the FIFO continue draining.
- Stage 2: round-robin arbiter over `pend_v`. Pointer `rr_q` (reset 0). The grant goes to the first pending hart at index ≥ `rr_q`, wrapping. A grant happens only when the FIFO can push. On grant g, `rr_q <= (g+1) mod NUM_HARTS`. With no grant, `rr_q` holds.
- FIFO can push when `level < DEPTH`, or when `level == DEPTH` and a pop occurs this cycle.
- FIFO pop: `tr_valid_o & tr_ready_i`. Head outputs come combinationally from registered storage. Read/write pointers are `$clog2(DEPTH)` bits and wrap naturally.
- Drop counter: adds the number of drops this cycle (0..NUM_HARTS) and saturates at 0xFFFF. If `drop_clr_i` is high, the next value is this cycle's drop count. Clear has priority over the old value.

## Timing
- Reset values:
  - outputs: `tr_valid_o`=0, `level_o`=0, `drop_cnt_o`=0, `tr_ts_o`=0;
  - state: all `pend_v`=0, `rr_q`=0, pointers=0, timestamp=0.
  - Payload outputs `tr_hart_o`/`tr_pc_o`/`tr_instr_o`/`tr_illegal_o` read 0 after reset.
- Latency: an event sampled at edge N is pending after N and in the FIFO after N+1. `tr_valid_o` is high in the cycle after edge N+1 when the FIFO was empty and the hart was granted. Minimum latency is 2 cycles.
- A pending register may be granted and refilled on the same edge. This sustains 1 event/cycle for a single hart with no drops.
- Throughput is 1 FIFO push/cycle total. With N harts all streaming, at most one pending drains per cycle; the rest drop once held.
- Full FIFO with simultaneous push and pop: both occur and `level_o` is unchanged.
- Empty FIFO: `tr_ready_i` is ignored; no bypass from stage 1 to output.
- `tr_valid_o` and the payload stay stable until accepted.
- Reset asserted mid-stream discards all pending and FIFO contents on that edge. The drop counter and timestamp also clear.

## Configuration
- `CV32E41P_TRACE_TIMESTAMP_EN` defined:
  - a TS_W free-running cycle counter (reset 0, wraps) is latched into the pending register at event acceptance;
  - the latched value is stored per FIFO entry and presented on `tr_ts_o`.
- Undefined: no counter, no timestamp storage, no `tr_ts_o` port. All other behaviour is identical.

## Test plan
- Single event: after reset, hart 0 pulses `ev_valid_i` with PC 0x0000_0080, instr 0x0000_0013, `tr_ready_i`=1 → `tr_valid_o` high exactly 2 cycles later with `tr_hart_o`=0, PC 0x80, instr 0x13, then `level_o`=0; with macro, `tr_ts_o`=sample cycle.
- Round-robin: harts 0 and 1 both assert for one cycle (PCs 0x100/0x200) → FIFO order is hart0 then hart1. Repeat with `rr_q`=1 → hart1 then hart0. `drop_cnt_o`=0.
- Full FIFO: `tr_ready_i`=0, hart 0 streams `DEPTH`+2 consecutive events → `level_o`=DEPTH, one event held pending, one dropped, `drop_cnt_o`=1. Raising `tr_ready_i` drains DEPTH+1 entries in order.
- Saturation/clear: force 0x10000 drops → `drop_cnt_o`=0xFFFF. Pulse `drop_clr_i` in a cycle with 2 drops → `drop_cnt_o`=2.
- Enable gating: `enable_i`=0 while harts assert `ev_valid_i` for 10 cycles → no FIFO entries, `drop_cnt_o`=0. Previously queued entries still drain.
- Reset mid-operation: with 5 entries queued and pendings full, assert `rst_i` one cycle → next cycle `tr_valid_o`=0, `level_o`=0, `drop_cnt_o`=0, `rr_q`=0.

Source files
------------

// File: rtl/cv32e41p_trace_buffer.sv
// Multi-hart retired-instruction trace buffer: per-hart pending slot, round-robin into a shared FIFO.
// Optional per-entry timestamps are enabled by defining CV32E41P_TRACE_TIMESTAMP_EN.

module cv32e41p_trace_buffer_pend #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         accept,
    input  logic         grant,
    input  logic [W-1:0] d,
    output logic         vld,
    output logic [W-1:0] q
);
    // Accept wins over grant so a slot can drain and refill on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= 1'b0;
            q   <= '0;
        end else if (accept) begin
            vld <= 1'b1;
            q   <= d;
        end else if (grant) begin
            vld <= 1'b0;
        end
    end
endmodule

module cv32e41p_trace_buffer #(
    parameter int NUM_HARTS = 2,
    parameter int DEPTH     = 8,
    parameter int TS_W      = 32,
    parameter int HART_W    = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       enable_i,
    input  logic [NUM_HARTS-1:0]       ev_valid_i,
    input  logic [NUM_HARTS-1:0][31:0] ev_pc_i,
    input  logic [NUM_HARTS-1:0][31:0] ev_instr_i,
    input  logic [NUM_HARTS-1:0]       ev_illegal_i,
    output logic                       tr_valid_o,
    input  logic                       tr_ready_i,
    output logic [HART_W-1:0]          tr_hart_o,
    output logic [31:0]                tr_pc_o,
    output logic [31:0]                tr_instr_o,
    output logic                       tr_illegal_o,
`ifdef CV32E41P_TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]            tr_ts_o,
`endif
    output logic [$clog2(DEPTH):0]     level_o,
    output logic [15:0]                drop_cnt_o,
    input  logic                       drop_clr_i
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
`ifdef CV32E41P_TRACE_TIMESTAMP_EN
        logic [TS_W-1:0]   ts;
`endif
        logic              illegal;
        logic [31:0]       instr;
        logic [31:0]       pc;
        logic [HART_W-1:0] hart;
    } entry_t;

    localparam int EW = $bits(entry_t);

    entry_t [NUM_HARTS-1:0] pend_q;
    logic   [NUM_HARTS-1:0] pend_v;
    logic   [NUM_HARTS-1:0] accept;
    logic   [NUM_HARTS-1:0] drop;
    logic   [NUM_HARTS-1:0] gnt;
    logic   [HART_W-1:0]    gnt_idx;
    logic   [HART_W-1:0]    rr_q;
    entry_t                 wr_data;
    logic                   push;
    logic                   pop;
    logic                   can_push;

    entry_t                 mem [DEPTH];
    entry_t                 head;
    logic   [PTR_W-1:0]     wr_ptr;
    logic   [PTR_W-1:0]     rd_ptr;
    logic   [LVL_W-1:0]     level;

    logic   [3:0]           drop_num;
    logic   [16:0]          drop_sum;
    logic   [15:0]          drop_cnt;

`ifdef CV32E41P_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) ts_q <= '0;
        else       ts_q <= ts_q + 1'b1;
    end
`endif

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        entry_t d;
        entry_t q;

        always_comb begin
            d.hart    = HART_W'(h);
            d.pc      = ev_pc_i[h];
            d.instr   = ev_instr_i[h];
            d.illegal = ev_illegal_i[h];
`ifdef CV32E41P_TRACE_TIMESTAMP_EN
            d.ts      = ts_q;
`endif
        end

        // Disabled capture neither accepts nor counts a drop.
        assign accept[h] = enable_i & ev_valid_i[h] & (~pend_v[h] | gnt[h]);
        assign drop[h]   = enable_i & ev_valid_i[h] & pend_v[h] & ~gnt[h];

        cv32e41p_trace_buffer_pend #(.W(EW)) u_pend (
            .clk    (clk_i),
            .rst    (rst_i),
            .accept (accept[h]),
            .grant  (gnt[h]),
            .d      (d),
            .vld    (pend_v[h]),
            .q      (q)
        );

        assign pend_q[h] = q;
    end

    assign tr_valid_o = (level != '0);
    assign pop        = tr_valid_o & tr_ready_i;
    assign can_push   = (level != LVL_W'(DEPTH)) | pop;

    // Two passes: harts at or above the pointer first, then the wrapped remainder.
    always_comb begin
        gnt     = '0;
        push    = 1'b0;
        gnt_idx = '0;
        wr_data = '0;
        if (can_push) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (!push && pend_v[h] && h >= int'(rr_q)) begin
                    push    = 1'b1;
                    gnt[h]  = 1'b1;
                    gnt_idx = HART_W'(h);
                    wr_data = pend_q[h];
                end
            end
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (!push && pend_v[h] && h < int'(rr_q)) begin
                    push    = 1'b1;
                    gnt[h]  = 1'b1;
                    gnt_idx = HART_W'(h);
                    wr_data = pend_q[h];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            rr_q   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LVL_W'(push) - LVL_W'(pop);
            if (push) rr_q <= (int'(gnt_idx) == NUM_HARTS - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_comb begin
        drop_num = '0;
        for (int h = 0; h < NUM_HARTS; h++) drop_num = drop_num + 4'(drop[h]);
    end

    assign drop_sum = {1'b0, drop_cnt} + 17'(drop_num);

    always_ff @(posedge clk_i) begin
        if (rst_i)           drop_cnt <= '0;
        else if (drop_clr_i) drop_cnt <= 16'(drop_num);
        else if (drop_sum[16]) drop_cnt <= 16'hFFFF;
        else                 drop_cnt <= drop_sum[15:0];
    end

    // Storage is unreset, so the head is masked to zero while the FIFO is empty.
    assign head         = tr_valid_o ? mem[rd_ptr] : '0;
    assign tr_hart_o    = head.hart;
    assign tr_pc_o      = head.pc;
    assign tr_instr_o   = head.instr;
    assign tr_illegal_o = head.illegal;
`ifdef CV32E41P_TRACE_TIMESTAMP_EN
    assign tr_ts_o      = head.ts;
`endif
    assign level_o      = level;
    assign drop_cnt_o   = drop_cnt;

endmodule

// File: tb/tb_cv32e41p_trace_buffer.sv
// Directed bench for cv32e41p_trace_buffer: scoreboard of expected FIFO entries checked at each pop.
// Timestamp checks compile in when CV32E41P_TRACE_TIMESTAMP_EN is defined.

module tb_cv32e41p_trace_buffer;
    localparam int NUM_HARTS = 2;
    localparam int DEPTH     = 8;
    localparam int TS_W      = 32;
    localparam int HART_W    = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       enable;
    logic [NUM_HARTS-1:0]       ev_valid;
    logic [NUM_HARTS-1:0][31:0] ev_pc;
    logic [NUM_HARTS-1:0][31:0] ev_instr;
    logic [NUM_HARTS-1:0]       ev_illegal;
    logic                       tr_valid;
    logic                       tr_ready;
    logic [HART_W-1:0]          tr_hart;
    logic [31:0]                tr_pc;
    logic [31:0]                tr_instr;
    logic                       tr_illegal;
    logic [$clog2(DEPTH):0]     level;
    logic [15:0]                drop_cnt;
    logic                       drop_clr;
`ifdef CV32E41P_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]            tr_ts;
`endif

    always #5 clk = ~clk;

    cv32e41p_trace_buffer #(
        .NUM_HARTS (NUM_HARTS),
        .DEPTH     (DEPTH),
        .TS_W      (TS_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .ev_valid_i   (ev_valid),
        .ev_pc_i      (ev_pc),
        .ev_instr_i   (ev_instr),
        .ev_illegal_i (ev_illegal),
        .tr_valid_o   (tr_valid),
        .tr_ready_i   (tr_ready),
        .tr_hart_o    (tr_hart),
        .tr_pc_o      (tr_pc),
        .tr_instr_o   (tr_instr),
        .tr_illegal_o (tr_illegal),
`ifdef CV32E41P_TRACE_TIMESTAMP_EN
        .tr_ts_o      (tr_ts),
`endif
        .level_o      (level),
        .drop_cnt_o   (drop_cnt),
        .drop_clr_i   (drop_clr)
    );

    typedef struct {
        logic [HART_W-1:0] hart;
        logic [31:0]       pc;
        logic [31:0]       instr;
        logic              illegal;
        logic [TS_W-1:0]   ts;
    } exp_t;

    exp_t            sb[$];
    int              checks = 0;
    int              errors = 0;
    logic [TS_W-1:0] ts_model;

    // Cycle count since reset; equals the value the design latches at the next edge.
    always @(posedge clk) begin
        if (rst) ts_model <= '0;
        else     ts_model <= ts_model + 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ev(input int h, input logic [31:0] pc, input logic [31:0] instr, input logic ill);
        ev_valid[h]   = 1'b1;
        ev_pc[h]      = pc;
        ev_instr[h]   = instr;
        ev_illegal[h] = ill;
    endtask

    task automatic clear_ev();
        ev_valid = '0;
    endtask

    task automatic push_exp(input int h, input logic [31:0] pc, input logic [31:0] instr, input logic ill);
        exp_t e;
        e.hart    = HART_W'(h);
        e.pc      = pc;
        e.instr   = instr;
        e.illegal = ill;
        e.ts      = ts_model;
        sb.push_back(e);
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            step();
            n++;
        end
        check("drain_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    // Every accepted head is compared against the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && tr_valid && tr_ready) begin
            if (sb.size() == 0) begin
                check("pop_without_expectation", 64'(sb.size()), 64'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pop_hart",    64'(tr_hart),    64'(e.hart));
                check("pop_pc",      64'(tr_pc),      64'(e.pc));
                check("pop_instr",   64'(tr_instr),   64'(e.instr));
                check("pop_illegal", 64'(tr_illegal), 64'(e.illegal));
`ifdef CV32E41P_TRACE_TIMESTAMP_EN
                check("pop_ts",      64'(tr_ts),      64'(e.ts));
`endif
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; enable = 1'b1; ev_valid = '0; ev_pc = '0; ev_instr = '0; ev_illegal = '0;
        tr_ready = 1'b0; drop_clr = 1'b0;
        step(); step();
        check("rst_valid",   64'(tr_valid),   64'd0);
        check("rst_level",   64'(level),      64'd0);
        check("rst_drop",    64'(drop_cnt),   64'd0);
        check("rst_hart",    64'(tr_hart),    64'd0);
        check("rst_pc",      64'(tr_pc),      64'd0);
        check("rst_instr",   64'(tr_instr),   64'd0);
        check("rst_illegal", 64'(tr_illegal), 64'd0);
        rst = 1'b0;

        // Single event: visible two edges after sampling.
        tr_ready = 1'b1;
        set_ev(0, 32'h80, 32'h13, 1'b0);
        push_exp(0, 32'h80, 32'h13, 1'b0);
        step();
        clear_ev();
        check("single_valid_early", 64'(tr_valid), 64'd0);
        step();
        check("single_valid", 64'(tr_valid), 64'd1);
        check("single_hart",  64'(tr_hart),  64'd0);
        check("single_pc",    64'(tr_pc),    64'h80);
        check("single_instr", 64'(tr_instr), 64'h13);
        step();
        check("single_valid_after", 64'(tr_valid), 64'd0);
        check("single_level_after", 64'(level),    64'd0);

        // Pointer now 1: hart 1 wins the simultaneous pair.
        set_ev(0, 32'h100, 32'hA0, 1'b0);
        set_ev(1, 32'h200, 32'hB0, 1'b0);
        push_exp(1, 32'h200, 32'hB0, 1'b0);
        push_exp(0, 32'h100, 32'hA0, 1'b0);
        step();
        clear_ev();
        drain(10);
        set_ev(1, 32'h300, 32'hC0, 1'b1);
        push_exp(1, 32'h300, 32'hC0, 1'b1);
        step();
        clear_ev();
        drain(10);
        // Pointer now 0: hart 0 first.
        set_ev(0, 32'h104, 32'hA4, 1'b0);
        set_ev(1, 32'h204, 32'hB4, 1'b1);
        push_exp(0, 32'h104, 32'hA4, 1'b0);
        push_exp(1, 32'h204, 32'hB4, 1'b1);
        step();
        clear_ev();
        drain(10);
        check("rr_drop", 64'(drop_cnt), 64'd0);

        // Full FIFO: DEPTH stored, one pending, one dropped.
        tr_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            set_ev(0, 32'h1000 + 32'(4 * i), 32'(i), i[0]);
            if (i < DEPTH + 1) push_exp(0, 32'h1000 + 32'(4 * i), 32'(i), i[0]);
            step();
        end
        clear_ev();
        check("full_level", 64'(level),    64'(DEPTH));
        check("full_drop",  64'(drop_cnt), 64'd1);
        check("full_valid", 64'(tr_valid), 64'd1);
        check("full_head",  64'(tr_pc),    64'h1000);
        step(); step();
        check("full_level_hold", 64'(level), 64'(DEPTH));
        check("full_head_hold",  64'(tr_pc), 64'h1000);
        tr_ready = 1'b1;
        drain(DEPTH + 5);
        check("full_level_drained", 64'(level),    64'd0);
        check("full_drop_after",    64'(drop_cnt), 64'd1);

        drop_clr = 1'b1;
        step();
        drop_clr = 1'b0;
        check("clr_no_drops", 64'(drop_cnt), 64'd0);

        // Enable gating: queued entries survive, gated events neither queue nor drop.
        tr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_ev(0, 32'h2000 + 32'(4 * i), 32'h2000 + 32'(i), 1'b0);
            push_exp(0, 32'h2000 + 32'(4 * i), 32'h2000 + 32'(i), 1'b0);
            step();
        end
        clear_ev();
        step(); step();
        check("gate_level_before", 64'(level), 64'd3);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_ev(0, 32'h3000, 32'h1, 1'b0);
            set_ev(1, 32'h3100, 32'h2, 1'b0);
            step();
        end
        clear_ev();
        step();
        check("gate_level", 64'(level),    64'd3);
        check("gate_drop",  64'(drop_cnt), 64'd0);
        enable = 1'b1;
        tr_ready = 1'b1;
        drain(10);
        check("gate_level_drained", 64'(level), 64'd0);

        // Saturation: 1 drop/cycle while filling, then 2/cycle once full.
        tr_ready = 1'b0;
        set_ev(0, 32'h4000, 32'h4, 1'b0);
        set_ev(1, 32'h4100, 32'h5, 1'b0);
        for (int k = 1; k <= 32800; k++) begin
            step();
            if (k == 20) check("sat_partial", 64'(drop_cnt), 64'd30);
        end
        check("sat_value", 64'(drop_cnt), 64'hFFFF);
        check("sat_level", 64'(level),    64'(DEPTH));
        drop_clr = 1'b1;
        step();
        drop_clr = 1'b0;
        clear_ev();
        check("clr_with_drops", 64'(drop_cnt), 64'd2);

        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst1_valid", 64'(tr_valid), 64'd0);
        check("rst1_level", 64'(level),    64'd0);
        check("rst1_drop",  64'(drop_cnt), 64'd0);

        // Five queued, both pendings full, pointer at 1, then reset.
        set_ev(0, 32'h4000, 32'h4, 1'b0);
        set_ev(1, 32'h4100, 32'h5, 1'b0);
        for (int k = 0; k < 6; k++) step();
        check("mid_level", 64'(level),    64'd5);
        check("mid_drop",  64'(drop_cnt), 64'd5);
        clear_ev();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", 64'(tr_valid), 64'd0);
        check("mid_rst_level", 64'(level),    64'd0);
        check("mid_rst_drop",  64'(drop_cnt), 64'd0);
        check("mid_rst_pc",    64'(tr_pc),    64'd0);

        // Pointer back at 0 and no stale pending entries emerge.
        tr_ready = 1'b1;
        set_ev(0, 32'h500, 32'h50, 1'b0);
        set_ev(1, 32'h600, 32'h60, 1'b0);
        push_exp(0, 32'h500, 32'h50, 1'b0);
        push_exp(1, 32'h600, 32'h60, 1'b0);
        step();
        clear_ev();
        drain(10);
        step(); step(); step();
        check("post_rst_idle_valid", 64'(tr_valid), 64'd0);
        check("post_rst_drop",       64'(drop_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
